// File: rtl/seg_bus_monitor_pkg.sv
// Shared definitions for the seven-segment bus monitor.
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : active-low segment glyphs, bit0=a .. bit6=g
//   AN_NONE                 : anode bus with no digit selected
//   AN_SEC1..AN_MIN2        : anode bit index of each displayed digit
//   mon_state_e             : capture FSM state encoding
//   an_is_one_hot           : true when exactly one anode is driven low
package seg_bus_monitor_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_NONE = 4'b1111;

  localparam int AN_SEC1 = 0;
  localparam int AN_SEC2 = 1;
  localparam int AN_MIN1 = 2;
  localparam int AN_MIN2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } mon_state_e;

  function automatic logic an_is_one_hot(input logic [3:0] i_an);
    return ($countones(~i_an) == 1);
  endfunction

endpackage

// File: rtl/seg_bus_monitor_decode.sv
// Combinational seven-segment glyph decoder.
// Ports:
//   i_seg   : active-low segment pattern, bit0=a .. bit6=g
//   o_bcd   : decoded digit 0-9 (0 when the pattern is not a digit)
//   o_valid : 1 when i_seg is exactly one of the ten digit glyphs
module seg_decode
  import seg_bus_monitor_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_valid
);

  always_comb begin
    o_bcd   = 4'd0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_bus_monitor.sv
// Receive-side monitor for a multiplexed four-digit seven-segment bus.
// Samples seg/an, waits for a pattern to hold steady, then reconstructs the
// displayed digit as BCD. Also flags blanking and illegal anode patterns.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   seg[6:0]        : active-low segment bus (bit0=a .. bit6=g)
//   an[3:0]         : active-low anode bus (an[0]=seconds1 .. an[3]=minutes2)
//   seconds1..minutes2 : captured BCD digits
//   digit_valid[3:0]: last capture of each digit decoded to 0-9
//   frame_done      : 1-cycle pulse once all four digits captured
//   blanked         : level, no anode active for BLANK_CYCLES
//   bus_error       : 1-cycle pulse on a stable multi-hot anode pattern
module seg_bus_monitor
  import seg_bus_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int BLANK_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] seconds1,
  output logic [3:0] seconds2,
  output logic [3:0] minutes1,
  output logic [3:0] minutes2,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       blanked,
  output logic       bus_error
);

  localparam int STW = $clog2(STABLE_CYCLES) + 1;
  localparam int BLW = $clog2(BLANK_CYCLES) + 1;
  localparam logic [STW-1:0] STABLE_LAST = STW'(STABLE_CYCLES - 1);
  localparam logic [BLW-1:0] BLANK_MAX   = BLW'(BLANK_CYCLES);
  localparam logic [BLW-1:0] BLANK_PRE   = BLW'(BLANK_CYCLES - 1);

  // Synchronisers reset to all ones so the bus looks idle out of reset.
  logic [6:0] r_seg_sync [SYNC_STAGES];
  logic [3:0] r_an_sync  [SYNC_STAGES];
  logic [6:0] w_seg;
  logic [3:0] w_an;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_seg_sync[i] <= '1;
        r_an_sync[i]  <= '1;
      end
    end else begin
      r_seg_sync[0] <= seg;
      r_an_sync[0]  <= an;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_seg_sync[i] <= r_seg_sync[i-1];
        r_an_sync[i]  <= r_an_sync[i-1];
      end
    end
  end

  assign w_seg = r_seg_sync[SYNC_STAGES-1];
  assign w_an  = r_an_sync[SYNC_STAGES-1];

  mon_state_e       r_state, w_next_state;
  logic [3:0]       r_snap_an;
  logic [6:0]       r_snap_seg;
  logic [STW-1:0]   r_stable_cnt;
  logic             w_match, w_load_snap, w_cnt_inc, w_capture;

  assign w_match = ({w_an, w_seg} == {r_snap_an, r_snap_seg});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load_snap  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_an != AN_NONE) begin
          w_next_state = ST_SETTLE;
          w_load_snap  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_match) begin
          if (r_stable_cnt == STABLE_LAST) begin
            w_capture    = 1'b1;
            w_next_state = ST_HOLD;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end else begin
          // Pattern moved: restart the stability window on the new pattern.
          w_load_snap = 1'b1;
          if (w_an == AN_NONE) w_next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Only an anode change ends a hold; segment changes on the same
        // anode are ignored until the digit is deselected.
        if (w_an != r_snap_an) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap_an    <= AN_NONE;
      r_snap_seg   <= SEG_BLANK;
      r_stable_cnt <= '0;
    end else if (w_load_snap) begin
      r_snap_an    <= w_an;
      r_snap_seg   <= w_seg;
      r_stable_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_stable_cnt <= r_stable_cnt + STW'(1);
    end
  end

  logic [3:0] w_bcd;
  logic       w_dec_valid;
  logic       w_one_hot;
  logic [3:0] w_sel;

  seg_decode u_decode (
    .i_seg   (r_snap_seg),
    .o_bcd   (w_bcd),
    .o_valid (w_dec_valid)
  );

  assign w_one_hot = an_is_one_hot(r_snap_an);
  assign w_sel     = ~r_snap_an;

  logic [3:0]     r_digit [4];
  logic [3:0]     r_valid;
  logic [3:0]     r_seen;
  logic           r_frame_done;
  logic           r_bus_error;
  logic [BLW-1:0] r_blank_cnt;
  logic           w_blank_rise;

  assign w_blank_rise = (w_an == AN_NONE) && (r_blank_cnt == BLANK_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
      r_valid      <= 4'b0000;
      r_seen       <= 4'b0000;
      r_frame_done <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_bus_error  <= w_capture && !w_one_hot;
      r_frame_done <= (r_seen == 4'b1111);
      if (w_capture && w_one_hot) begin
        for (int i = 0; i < 4; i++) begin
          if (w_sel[i]) begin
            if (w_dec_valid) r_digit[i] <= w_bcd;
            r_valid[i] <= w_dec_valid;
          end
        end
        r_seen <= r_seen | w_sel;
      end else if ((r_seen == 4'b1111) || w_blank_rise) begin
        r_seen <= 4'b0000;
      end
    end
  end

  // Saturating idle counter; any active anode restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blank_cnt <= '0;
    end else if (w_an == AN_NONE) begin
      if (r_blank_cnt != BLANK_MAX) r_blank_cnt <= r_blank_cnt + BLW'(1);
    end else begin
      r_blank_cnt <= '0;
    end
  end

  assign seconds1    = r_digit[AN_SEC1];
  assign seconds2    = r_digit[AN_SEC2];
  assign minutes1    = r_digit[AN_MIN1];
  assign minutes2    = r_digit[AN_MIN2];
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign bus_error   = r_bus_error;
  assign blanked     = (r_blank_cnt == BLANK_MAX);

endmodule

// File: doc/seg_bus_monitor.md
Name: seg_bus_monitor

Overview:
- Receive-side counterpart of the display driver: samples the multiplexed seven-segment bus (seg/an) and reconstructs the four displayed digits as BCD.
- Used as an on-board self-check and by benches to read watch state without probing the counter.
- Detects flash blanking (set mode), illegal anode patterns and undecodable segment patterns.

Parameters:
- SYNC_STAGES, 2, synchroniser depth applied to seg and an.
- STABLE_CYCLES, 16, consecutive clk cycles a one-hot anode plus segment pattern must hold before capture.
- BLANK_CYCLES, 500000, clk cycles with all anodes inactive before blanked asserts.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- seg  in  7  segment bus, active-low, bit0=a .. bit6=g
- an  in  4  anode bus, active-low, an[0]=seconds1 .. an[3]=minutes2
- seconds1  out  4  captured BCD digit for an[0]
- seconds2  out  4  captured BCD digit for an[1]
- minutes1  out  4  captured BCD digit for an[2]
- minutes2  out  4  captured BCD digit for an[3]
- digit_valid  out  4  per-digit: last capture decoded to 0-9
- frame_done  out  1  one-cycle pulse when all four anodes captured since previous pulse
- blanked  out  1  level: no anode active for BLANK_CYCLES
- bus_error  out  1  one-cycle pulse on multi-hot anode held STABLE_CYCLES

Behaviour:
- Reset (rst=0, async): digits 0, digit_valid 0000, frame_done 0, blanked 0, bus_error 0, FSM IDLE, seen-mask 0000, counters 0, synchroniser flops all ones (inactive bus).
- Input path: seg and an pass SYNC_STAGES flops; all logic uses synchronised copies.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: any anode low -> SETTLE, stable counter cleared; latch {an,seg} snapshot.
  - SETTLE: counter increments while {an,seg} equals snapshot; mismatch -> restart with new snapshot (stay SETTLE, or IDLE if an=1111). Counter reaches STABLE_CYCLES-1 -> capture, go HOLD.
  - HOLD: stay until an differs from snapshot, then -> IDLE same cycle logic (re-evaluated next cycle).
- Capture, one-hot an: decode seg; selected digit register <= value, digit_valid bit <= 1; undecodable pattern -> digit register unchanged, valid bit <= 0. Seen-mask bit set.
- Capture, multi-hot an: no digit update, bus_error pulses 1 cycle, seen-mask untouched.
- Decode table (seg[6:0], active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Anything else (incl. 1111111) invalid.
- frame_done: cycle after the capture that makes seen-mask 1111, pulse 1 cycle and clear seen-mask same cycle. Capture order irrelevant; repeat captures of an already seen digit have no effect on mask.
- Latency: bus change to digit update = SYNC_STAGES + STABLE_CYCLES + 1 cycles.
- Blank counter: increments each cycle synchronised an=1111, saturates at BLANK_CYCLES; any anode active clears it and blanked on the next cycle. blanked=1 when counter == BLANK_CYCLES. Digits hold last values while blanked; seen-mask cleared on blanked rising.
- Width: stable counter clog2(STABLE_CYCLES)+1 bits, blank counter clog2(BLANK_CYCLES)+1 bits; no wrap allowed.
- Reset mid-capture: all state aborted, no pulse emitted.

Decomposition:
- Shared package: segment constants SEG_0..SEG_9, SEG_BLANK, FSM state encoding, anode index constants.
- Sub-module seg_decode (combinational 7-bit pattern -> 4-bit BCD + valid), reusable by display tests.

Test Plan:
- Drive an=1110, seg=0010010 for 40 cycles -> seconds1=5, digit_valid[0]=1 at cycle 2+16+1 after edge.
- Cycle an through 1110,1101,1011,0111 with digits 3,4,2,1 (40 cycles each) -> frame_done single pulse after 4th capture; outputs 3,4,2,1.
- Hold an=1111 for BLANK_CYCLES (set 100 in bench) -> blanked=1 at cycle 102; drive an=1110 -> blanked=0 next cycle, digits unchanged.
- Drive an=1100 for 40 cycles -> bus_error one pulse, all digits unchanged.
- an=1101, seg=1111111 (blank glyph) -> digit_valid[1]=0, seconds2 retains prior value 4.
- Toggle seg every 10 cycles with an=1110 (glitching) -> no capture; deassert rst mid-SETTLE -> outputs all zero, no pulses.
